// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and defaults for the FIFO drain block: the
//               drain FSM state encoding and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_skid
// Description : Two-entry in-order skid buffer. Entry 0 is always the head,
//               so dout is a plain register output. Capture and pop in the
//               same cycle keep occupancy unchanged and preserve order.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] r_mem0;
  logic [DATA_WIDTH-1:0] r_mem1;
  logic [1:0]            r_occ;

  // Shift-style storage: pops move entry 1 into the head slot; pushes fill
  // the first free slot. The caller never pops empty or pushes when full.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_occ == 2'd0) r_mem0 <= din;
          else               r_mem1 <= din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_mem0 <= din;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout      = r_mem0;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Drains an upstream FIFO with a one-cycle read latency into a
//               two-entry skid buffer feeding a ready/valid consumer. Reads
//               are throttled so the buffer never overflows and, near the
//               FIFO's low threshold, never over-read.
//               Optional feature macro FIFO_DRAIN_CNT_EN adds a 16-bit
//               wrapping word_count output counting delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  input  logic                  FIFO_empty,
  input  logic                  FIFO_almost_empty,
  input  logic                  ready_in,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]           word_count
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic       r_pend;
  logic [1:0] w_occ;
  logic       w_pop;
  logic [2:0] w_level;
  logic [2:0] w_fill;
  logic       w_done;

  fifo_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .Reset    (Reset),
    .push     (r_pend),
    .pop      (w_pop),
    .din      (FIFO_data_out),
    .dout     (data_out),
    .occupancy(w_occ)
  );

  assign valid_out = (w_occ != 2'd0);
  assign w_pop     = valid_out & ready_in;
  assign busy      = (r_state != IDLE);

  // Words held or in flight, before and after this cycle's pop.
  assign w_fill  = {1'b0, w_occ} + {2'b00, r_pend};
  assign w_level = w_fill - {2'b00, w_pop};
  assign w_done  = (!Enable || FIFO_empty) && !r_pend && (w_occ == 2'd0);

  // Gating on a non-IDLE state delays the first read to the second edge
  // after reset release; the pend term spaces reads near the low threshold.
  assign read_enable = busy && Enable && !FIFO_empty && (w_level < 3'd2) &&
                       (!FIFO_almost_empty || !r_pend);

  // State and read-in-flight registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= read_enable;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (Enable && !FIFO_empty) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_done)                                w_next = IDLE;
        else if ((w_fill == 3'd2) && !ready_in)    w_next = HOLD;
      end
      HOLD: begin
        if (w_done)        w_next = IDLE;
        else if (ready_in) w_next = DRAIN;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] r_word_count;

  // Count delivered words; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)     r_word_count <= 16'd0;
    else if (w_pop) r_word_count <= r_word_count + 16'd1;
  end

  assign word_count = r_word_count;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, the width of every data word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Enable, input, 1 bit: permits new FIFO reads when high.
REQ-005 SHALL have port FIFO_data_out, input, DATA_WIDTH bits: the upstream FIFO read data, valid one cycle after read_enable.
REQ-006 SHALL have port FIFO_empty, input, 1 bit: the upstream FIFO is empty.
REQ-007 SHALL have port FIFO_almost_empty, input, 1 bit: the upstream FIFO is at or below its low threshold.
REQ-008 SHALL have port ready_in, input, 1 bit: the downstream consumer accepts data_out this cycle.
REQ-009 SHALL have port read_enable, output, 1 bit: the read strobe to the upstream FIFO.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits: the head word of the skid buffer.
REQ-011 SHALL have port valid_out, output, 1 bit: data_out holds a word.
REQ-012 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-013 SHALL have port word_count, output, 16 bits, present only under FIFO_DRAIN_CNT_EN: the number of words transferred.

Function
REQ-014 SHALL hold a 2-entry skid buffer (occupancy 0..2) plus a pend flag equal to read_enable registered one cycle.
REQ-015 SHALL write FIFO_data_out into the buffer tail in the cycle pend=1.
REQ-016 SHALL pop the buffer head in every cycle with valid_out=1 and ready_in=1.
REQ-017 SHALL handle a capture and a pop in the same cycle with occupancy unchanged and order preserved.
REQ-018 SHALL assert read_enable only when all of the following hold: Enable=1; FIFO_empty=0; occupancy+pend<2 after this cycle's pop; and either FIFO_almost_empty=0 or pend=0.
REQ-019 SHALL therefore issue back-to-back reads only above the low threshold, and at most one read per two cycles otherwise (no over-read).
REQ-020 SHALL make read_enable combinational from registered state and inputs.
REQ-021 SHALL implement a state machine with three states: IDLE, DRAIN and HOLD.
REQ-022 SHALL move from IDLE to DRAIN when Enable=1 and FIFO_empty=0.
REQ-023 SHALL move from DRAIN to HOLD when occupancy+pend=2 and ready_in=0.
REQ-024 SHALL move from HOLD to DRAIN on the first cycle with ready_in=1.
REQ-025 SHALL move from DRAIN or HOLD to IDLE when Enable=0 or FIFO_empty=1, and pend=0, and occupancy=0.
REQ-026 SHALL, when Enable falls mid-operation, stop issuing new reads, still capture any in-flight word, and deliver all buffered words downstream.
REQ-027 SHALL keep valid_out high and data_out stable while ready_in=0, never dropping or duplicating a word.
REQ-028 SHALL, when both buffer entries are full and ready_in=0, issue no read.

Reset
REQ-029 SHALL, while Reset=0, force state=IDLE, occupancy=0, pend=0, read_enable=0, valid_out=0, data_out=0, busy=0 and word_count=0.
REQ-030 SHALL, on reset asserted mid-operation, discard buffered and in-flight words; the FIFO data arriving in the following cycle is ignored.
REQ-031 SHALL issue its first read no earlier than the second clk edge after Reset rises.

Configuration
REQ-032 SHALL, with FIFO_DRAIN_CNT_EN defined, provide word_count, incremented on each pop and wrapping from 0xFFFF to 0.
REQ-033 SHALL, without FIFO_DRAIN_CNT_EN, omit the word_count port and the counter; all other behaviour is identical.

Structure
REQ-034 SHALL take the state encoding (IDLE=0, DRAIN=1, HOLD=2, 2 bits) and the DATA_WIDTH default from the shared package fifo_pkg.
REQ-035 SHALL place the skid buffer in sub-module fifo_drain_skid, with ports push, pop, din, dout, occupancy; the FSM and read gating stay in fifo_drain.

Verification
REQ-036 SHALL be covered by a steady-drain scenario: FIFO holds 6 words above threshold, ready_in=1 throughout -> read_enable high 6 consecutive cycles; words appear in order with 1-cycle latency; word_count=6.
REQ-037 SHALL be covered by a low-level scenario: FIFO holds 2 words with FIFO_almost_empty=1 -> read_enable pulses in non-adjacent cycles; exactly 2 words delivered; no read while FIFO_empty=1.
REQ-038 SHALL be covered by a backpressure scenario: ready_in=0 for 5 cycles with the FIFO non-empty -> occupancy reaches 2, state=HOLD, read_enable=0, data_out stable; on ready_in=1 the words drain in order with no loss.
REQ-039 SHALL be covered by an Enable-drop scenario: Enable falls the cycle after a read -> the in-flight word is captured and delivered; no further reads; state returns to IDLE, busy=0.
REQ-040 SHALL be covered by a reset-mid-operation scenario: Reset=0 with occupancy=2 -> valid_out=0 immediately; after release no stale word appears.
REQ-041 SHALL be covered by a counter-wrap scenario: with FIFO_DRAIN_CNT_EN defined, 65537 pops -> word_count=1.
